// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic datapath types, sizing and reference divide
package arith_pkg;

    // Operand width shared by the array multiplier and the iterative divider
    localparam int ARITH_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Returns {quotient, remainder} in two 32-bit halves; divide by zero yields
    // an all-ones quotient of the given width and the dividend as remainder.
    function automatic logic [63:0] div_ref(input logic [31:0] dividend,
                                            input logic [31:0] divisor,
                                            input int          width);
        logic [31:0] mask;
        logic [31:0] q;
        logic [31:0] r;
        mask = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
        if (divisor == 32'd0) begin
            q = mask;
            r = dividend;
        end else begin
            q = dividend / divisor;
            r = dividend % divisor;
        end
        return {q, r};
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one combinational restoring-division step
module div_restore_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] t;
    logic           ge;

    // Shift the next dividend bit into the partial remainder, subtract if it fits.
    // The restored remainder is always below the divisor, so WIDTH bits suffice.
    always_comb begin
        t      = {r, q[WIDTH-1]};
        ge     = (t >= {1'b0, divisor});
        r_next = ge ? WIDTH'(t - {1'b0, divisor}) : t[WIDTH-1:0];
        q_next = {q[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - iterative unsigned restoring divider with start/done handshake
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter  int WIDTH = ARITH_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r       (r_q),
        .q       (q_q),
        .divisor (d_q),
        .r_next  (r_next),
        .q_next  (q_next)
    );

    // Control FSM, iteration state and result registers. Results land on entry
    // to DONE; the done pulse follows one cycle later while the FSM is back in
    // IDLE, which is what lets a held start re-issue every WIDTH+2 cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        d_q  <= divisor;
                        if (divisor == '0) begin
                            state       <= S_DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            cnt   <= CNT_W'(WIDTH);
                            r_q   <= '0;
                            q_q   <= dividend;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_q <= r_next;
                    q_q <= q_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state       <= S_DONE;
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;
    import arith_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cycle = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    endtask

    // Behavioural model: a countdown to the done pulse plus the arithmetic result
    int rem_cycles = 0;
    int m_done = 0;
    int m_busy = 0;
    int m_q = 0;
    int m_r = 0;
    int m_dbz = 0;
    int p_q = 0;
    int p_r = 0;
    int p_dbz = 0;

    always @(posedge clk) begin
        cycle++;
        if (!rst_n) begin
            rem_cycles = 0;
            m_done = 0;
            m_busy = 0;
            m_q = 0;
            m_r = 0;
            m_dbz = 0;
        end else begin
            m_done = 0;
            if (rem_cycles > 0) begin
                rem_cycles--;
                if (rem_cycles == 0) m_done = 1;
            end else if (start) begin
                if (divisor == 0) begin
                    p_q = (1 << W) - 1;
                    p_r = int'(dividend);
                    p_dbz = 1;
                    rem_cycles = 1;
                end else begin
                    p_q = int'(dividend) / int'(divisor);
                    p_r = int'(dividend) % int'(divisor);
                    p_dbz = 0;
                    rem_cycles = W + 1;
                end
            end
            m_busy = (rem_cycles > 0 || m_done) ? 1 : 0;
            if (m_done) begin
                m_q = p_q;
                m_r = p_r;
                m_dbz = p_dbz;
            end
        end
    end

    // Every-cycle comparison; results are skipped only in the cycle between
    // their early registration and the done pulse.
    always @(negedge clk) begin
        if (checking) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            if (rem_cycles != 1) begin
                check("quotient", quotient, m_q);
                check("remainder", remainder, m_r);
                check("div_by_zero", div_by_zero, m_dbz);
            end
        end
    end

    task automatic start_op(input int a, input int b);
        @(negedge clk);
        #1;
        dividend = W'(a);
        divisor = W'(b);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = W'($urandom);
        divisor = W'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n - 1;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    task automatic issue(input int a, input int b, output int lat);
        start_op(a, b);
        wait_done(lat);
    endtask

    task automatic expect_result(input string name, input int a, input int b,
                                 input int eq, input int er, input int edbz, input int elat);
        int lat;
        issue(a, b, lat);
        check({name, "_lat"}, lat, elat);
        check({name, "_q"}, quotient, eq);
        check({name, "_r"}, remainder, er);
        check({name, "_dbz"}, div_by_zero, edbz);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int saw;
        int t_done[3];
        int nd;
        logic [63:0] ref_v;

        ref_v = div_ref(32'd13, 32'd3, W);
        check("div_ref_13_3", ref_v, {32'd4, 32'd1});
        ref_v = div_ref(32'd7, 32'd0, W);
        check("div_ref_7_0", ref_v, {32'd15, 32'd7});

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        checking = 1'b1;
        #1;
        rst_n = 1'b1;

        expect_result("basic_13_3", 13, 3, 4, 1, 0, W + 1);
        expect_result("edge_15_1", 15, 1, 15, 0, 0, W + 1);
        expect_result("edge_2_9", 2, 9, 0, 2, 0, W + 1);
        expect_result("edge_15_15", 15, 15, 1, 0, 0, W + 1);
        expect_result("edge_0_5", 0, 5, 0, 0, 0, W + 1);
        expect_result("dbz_7_0", 7, 0, 15, 7, 1, 1);
        expect_result("after_dbz_8_2", 8, 2, 4, 0, 0, W + 1);

        // Reset in the middle of RUN aborts without a done pulse
        start_op(13, 3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_q", quotient, 0);
        check("midrst_r", remainder, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) saw = 1;
        end
        check("midrst_no_done", saw, 0);
        expect_result("post_rst_9_2", 9, 2, 4, 1, 0, W + 1);

        // Start pulsed during RUN is ignored
        start_op(14, 3);
        @(negedge clk);
        #1;
        dividend = 4'd6;
        divisor = 4'd4;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        check("ignore_q", quotient, 4);
        check("ignore_r", remainder, 2);
        saw = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) saw = 1;
        end
        check("ignore_no_second_op", saw, 0);

        // Held start: accepts spaced WIDTH+2 cycles apart
        @(negedge clk);
        #1;
        dividend = 4'd13;
        divisor = 4'd3;
        start = 1'b1;
        nd = 0;
        for (int n = 0; n < 40 && nd < 3; n++) begin
            @(negedge clk);
            if (done) begin
                t_done[nd] = cycle;
                nd++;
            end
        end
        #1;
        start = 1'b0;
        check("held_count", nd, 3);
        if (nd == 3) begin
            check("held_gap0", t_done[1] - t_done[0], W + 2);
            check("held_gap1", t_done[2] - t_done[1], W + 2);
        end
        repeat (3) @(negedge clk);

        // Exhaustive pairs
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(a, b, lat);
                check("exh_lat", lat, (b == 0) ? 1 : W + 1);
                if (b != 0) begin
                    check("exh_invariant", int'(quotient) * b + int'(remainder), a);
                    check("exh_rem_lt", (int'(remainder) < b) ? 1 : 0, 1);
                end
            end
        end

        // Round trip through multiplier products that fit the operand width
        for (int b = 1; b < 16; b++) begin
            for (int a = 0; a < 16; a++) begin
                if (a * b < 16) begin
                    issue(a * b, b, lat);
                    check("rt_q", quotient, a);
                    check("rt_r", remainder, 0);
                end
            end
        end

        // Random operations with gaps and ignored start pulses during RUN
        for (int i = 0; i < 80; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, 15));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 15));
            start_op(a, b);
            if (b != 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(negedge clk);
                    #1;
                    start = 1'($urandom_range(0, 1));
                    dividend = W'($urandom);
                    divisor = W'($urandom);
                end
                @(negedge clk);
                #1;
                start = 1'b0;
            end
            wait_done(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
